// File: rtl/video_pkg.sv
// Raster timing defaults and shared types for the video fetch engine.
package video_pkg;

  localparam logic [15:0] FB_BASE_D = 16'h2000;
  localparam int H_ACTIVE_D = 40;
  localparam int H_TOTAL_D  = 65;
  localparam int V_ACTIVE_D = 192;
  localparam int V_TOTAL_D  = 262;
  localparam int HS_START_D = 48;
  localparam int HS_LEN_D   = 4;
  localparam int VS_START_D = 220;
  localparam int VS_LEN_D   = 3;

  localparam int POS_W = 10;

  typedef struct packed {
    logic [POS_W-1:0] h;
    logic [POS_W-1:0] v;
  } raster_pos_t;

  function automatic logic below(
    input logic [POS_W-1:0] x,
    input int lim
  );
    return int'(x) < lim;
  endfunction

  function automatic logic in_win(
    input logic [POS_W-1:0] x,
    input int s,
    input int l
  );
    return (int'(x) >= s) && (int'(x) < s + l);
  endfunction

endpackage

// File: rtl/video_fetch_gen_if.sv
// Memory-side and pixel-side bundle of the video fetch engine.
interface video_fetch_gen_if;

  logic        cpu_phi;
  logic        vid_phi;
  logic [15:0] vid_adr;
  logic [7:0]  ram_dbo;
  logic [7:0]  vid_byte;
  logic        vid_byte_vld;
  logic        hsync;
  logic        vsync;
  logic        blank;
  logic        frame_start;

  modport master (
    output cpu_phi,
    output vid_phi,
    output vid_adr,
    input  ram_dbo,
    output vid_byte,
    output vid_byte_vld,
    output hsync,
    output vsync,
    output blank,
    output frame_start
  );

  modport slave (
    input  cpu_phi,
    input  vid_phi,
    input  vid_adr,
    output ram_dbo,
    input  vid_byte,
    input  vid_byte_vld,
    input  hsync,
    input  vsync,
    input  blank,
    input  frame_start
  );

endinterface

// File: rtl/video_raster_cnt.sv
// Horizontal/vertical slot counters with wrap flags.
module video_raster_cnt
  import video_pkg::*;
#(
  parameter int H_TOTAL = H_TOTAL_D,
  parameter int V_TOTAL = V_TOTAL_D
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output raster_pos_t pos_o,
  output logic        h_wrap_o,
  output logic        v_wrap_o
);

  localparam logic [POS_W-1:0] H_LAST = POS_W'(H_TOTAL - 1);
  localparam logic [POS_W-1:0] V_LAST = POS_W'(V_TOTAL - 1);

  raster_pos_t pos_q;
  raster_pos_t pos_d;

  assign h_wrap_o = en_i && (pos_q.h == H_LAST);
  assign v_wrap_o = h_wrap_o && (pos_q.v == V_LAST);

  always_comb begin
    pos_d = pos_q;
    if (en_i) begin
      pos_d.h = h_wrap_o ? '0 : pos_q.h + 1'b1;
    end
    if (h_wrap_o) begin
      pos_d.v = v_wrap_o ? '0 : pos_q.v + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign pos_o = pos_q;

endmodule

// File: rtl/video_fetch_gen.sv
// Video timing and framebuffer fetch engine: interleave phase,
// fetch address, byte capture and sync/blank alignment.
module video_fetch_gen
  import video_pkg::*;
#(
  parameter logic [15:0] FB_BASE = FB_BASE_D,
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_TOTAL  = H_TOTAL_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_TOTAL  = V_TOTAL_D,
  parameter int HS_START = HS_START_D,
  parameter int HS_LEN   = HS_LEN_D,
  parameter int VS_START = VS_START_D,
  parameter int VS_LEN   = VS_LEN_D
) (
  input  logic              mem_phi,
  input  logic              rst,
  video_fetch_gen_if.master bus
);

  localparam logic [15:0] LINE_STEP = 16'(H_ACTIVE);

  raster_pos_t pos;
  logic        h_wrap;
  logic        v_wrap;
  logic        slot_end;

  logic        phase_q;
  logic [15:0] base_q;
  logic [15:0] base_d;
  logic [15:0] adr;

  logic        v_act;
  logic        act;
  logic        hs;
  logic        vs;

  logic        pend_q;
  logic        pact_q;
  logic        phs_q;
  logic        pvs_q;

  logic [7:0]  byte_q;
  logic        vld_q;
  logic        hsync_q;
  logic        vsync_q;
  logic        blank_q;
  logic        fs_q;

  // The second cycle of each slot is the edge the decoder latches on.
  assign slot_end = phase_q;

  video_raster_cnt #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_cnt (
    .clk_i    (mem_phi),
    .rst_i    (rst),
    .en_i     (slot_end),
    .pos_o    (pos),
    .h_wrap_o (h_wrap),
    .v_wrap_o (v_wrap)
  );

  always_comb begin
    v_act = below(pos.v, V_ACTIVE);
    act   = v_act && below(pos.h, H_ACTIVE);
    hs    = in_win(pos.h, HS_START, HS_LEN);
    vs    = in_win(pos.v, VS_START, VS_LEN);
  end

  assign adr = act ? base_q + 16'(pos.h) : base_q;

  always_comb begin
    base_d = base_q;
    if (v_wrap) begin
      base_d = FB_BASE;
    end else if (h_wrap && v_act) begin
      base_d = base_q + LINE_STEP;
    end
  end

  always_ff @(posedge mem_phi or posedge rst) begin
    if (rst) begin
      phase_q <= 1'b0;
      base_q  <= FB_BASE;
      fs_q    <= 1'b0;
    end else begin
      phase_q <= ~phase_q;
      base_q  <= base_d;
      fs_q    <= v_wrap;
    end
  end

  // Slot attributes wait one cycle so they leave with the RAM data.
  always_ff @(posedge mem_phi or posedge rst) begin
    if (rst) begin
      pend_q <= 1'b0;
      pact_q <= 1'b0;
      phs_q  <= 1'b0;
      pvs_q  <= 1'b0;
    end else begin
      pend_q <= slot_end;
      if (slot_end) begin
        pact_q <= act;
        phs_q  <= hs;
        pvs_q  <= vs;
      end
    end
  end

  always_ff @(posedge mem_phi or posedge rst) begin
    if (rst) begin
      byte_q  <= 8'h00;
      vld_q   <= 1'b0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      blank_q <= 1'b1;
    end else begin
      vld_q <= pend_q && pact_q;
      if (pend_q) begin
        hsync_q <= phs_q;
        vsync_q <= pvs_q;
        blank_q <= ~pact_q;
      end
      if (pend_q && pact_q) begin
        byte_q <= bus.ram_dbo;
      end
    end
  end

  assign bus.cpu_phi      = phase_q;
  assign bus.vid_phi      = ~phase_q;
  assign bus.vid_adr      = adr;
  assign bus.vid_byte     = byte_q;
  assign bus.vid_byte_vld = vld_q;
  assign bus.hsync        = hsync_q;
  assign bus.vsync        = vsync_q;
  assign bus.blank        = blank_q;
  assign bus.frame_start  = fs_q;

endmodule

// File: tb/tb_video_fetch_gen.sv
// Directed bench for video_fetch_gen: default and reduced timing.
module tb_video_fetch_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  video_fetch_gen_if vif ();
  video_fetch_gen_if sif ();

  video_fetch_gen dut (
    .mem_phi (clk),
    .rst     (rst),
    .bus     (vif.master)
  );

  video_fetch_gen #(
    .H_ACTIVE (2),
    .H_TOTAL  (4),
    .V_ACTIVE (2),
    .V_TOTAL  (3),
    .HS_START (2),
    .HS_LEN   (1),
    .VS_START (2),
    .VS_LEN   (1)
  ) dut_s (
    .mem_phi (clk),
    .rst     (rst),
    .bus     (sif.master)
  );

  // RAM answers the latched address with its low byte one cycle later
  logic [7:0] ram_q = 8'h00;
  always @(posedge clk) begin
    if (vif.cpu_phi) ram_q <= vif.vid_adr[7:0];
  end
  assign vif.ram_dbo = ram_q;
  assign sif.ram_dbo = 8'h00;

  int n_vec = 0;
  int n_err = 0;
  int edge_n = 0;
  int fs_cnt = 0;
  int fs_edge = -1;
  int nstb = 0;
  int hs_cnt = 0;
  int hs_first = -1;
  int bl_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic adv_to(input int e);
    while (edge_n < e) begin
      @(negedge clk);
      edge_n++;
      if (vif.frame_start) begin
        fs_cnt++;
        fs_edge = edge_n;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cpu_phi", 32'(vif.cpu_phi), 0);
    chk("rst_vid_phi", 32'(vif.vid_phi), 1);
    chk("rst_adr", 32'(vif.vid_adr), 'h2000);
    chk("rst_blank", 32'(vif.blank), 1);
    chk("rst_vld", 32'(vif.vid_byte_vld), 0);
    chk("rst_hs", 32'(vif.hsync), 0);
    chk("rst_fs", 32'(vif.frame_start), 0);
    chk("sm_adr0", 32'(sif.vid_adr), 'h2000);

    rst = 1'b0;
    edge_n = 0;
    for (int c = 0; c < 130; c++) begin
      adv_to(edge_n + 1);
      if (edge_n <= 4)
        chk("phase", 32'(vif.cpu_phi), 32'(edge_n & 1));
      if (vif.vid_byte_vld) begin
        chk("line0_byte", 32'(vif.vid_byte), 32'(nstb));
        chk("line0_blank", 32'(vif.blank), 0);
        nstb++;
      end
      if (vif.hsync) begin
        if (hs_cnt == 0) hs_first = edge_n;
        hs_cnt++;
      end
      if (!vif.blank) bl_cnt++;
      case (edge_n)
        2:  chk("sm_adr1", 32'(sif.vid_adr), 'h2001);
        8:  chk("sm_adr2", 32'(sif.vid_adr), 'h2002);
        10: chk("sm_adr3", 32'(sif.vid_adr), 'h2003);
        16: chk("sm_hold", 32'(sif.vid_adr), 'h2004);
        24: begin
          chk("sm_wrap", 32'(sif.vid_adr), 'h2000);
          chk("sm_fs", 32'(sif.frame_start), 1);
        end
        default: ;
      endcase
    end
    chk("line0_nstb", 32'(nstb), 40);
    chk("hs_cycles", 32'(hs_cnt), 8);
    chk("hs_first", 32'(hs_first), 99);
    chk("blank_low", 32'(bl_cnt), 80);
    chk("line1_adr", 32'(vif.vid_adr), 'h2028);

    adv_to(24908);
    chk("last_adr", 32'(vif.vid_adr), 'h3DFF);
    adv_to(24910);
    chk("hold_adr", 32'(vif.vid_adr), 'h3DD8);
    adv_to(24911);
    chk("last_vld", 32'(vif.vid_byte_vld), 1);
    chk("last_byte", 32'(vif.vid_byte), 'hFF);

    adv_to(28602);
    chk("vs_pre", 32'(vif.vsync), 0);
    adv_to(28603);
    chk("vs_rise", 32'(vif.vsync), 1);
    adv_to(28992);
    chk("vs_hold", 32'(vif.vsync), 1);
    adv_to(28993);
    chk("vs_fall", 32'(vif.vsync), 0);

    adv_to(34059);
    chk("fs_none", 32'(fs_cnt), 0);
    adv_to(34060);
    chk("fs_pulse", 32'(vif.frame_start), 1);
    chk("wrap_adr", 32'(vif.vid_adr), 'h2000);
    adv_to(34061);
    chk("fs_end", 32'(vif.frame_start), 0);
    chk("fs_cnt", 32'(fs_cnt), 1);
    chk("fs_edge", 32'(fs_edge), 34060);

    adv_to(40595);
    chk("mid_adr", 32'(vif.vid_adr), 'h27E1);
    chk("mid_blank", 32'(vif.blank), 0);
    #2 rst = 1'b1;
    #1;
    chk("ar_cpu_phi", 32'(vif.cpu_phi), 0);
    chk("ar_vid_phi", 32'(vif.vid_phi), 1);
    chk("ar_adr", 32'(vif.vid_adr), 'h2000);
    chk("ar_blank", 32'(vif.blank), 1);
    chk("ar_vld", 32'(vif.vid_byte_vld), 0);
    @(negedge clk);
    rst = 1'b0;
    edge_n = 0;
    adv_to(1);
    chk("rs_phase", 32'(vif.cpu_phi), 1);
    chk("rs_no_fs", 32'(vif.frame_start), 0);
    adv_to(2);
    chk("rs_adr", 32'(vif.vid_adr), 'h2001);
    adv_to(3);
    chk("rs_vld", 32'(vif.vid_byte_vld), 1);
    chk("rs_byte", 32'(vif.vid_byte), 'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
